grf_scoreboard: RTL and testbench

GRF_SCOREBOARD -- requirements
Module: grf_scoreboard

---
 rtl/grf_scoreboard_pkg.sv | 16 +
 rtl/sb_entry.sv | 54 +++++
 rtl/grf_scoreboard.sv | 70 +++++++
 tb/tb_grf_scoreboard.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/grf_scoreboard_pkg.sv
// Shared constants for the GRF scoreboard and the hazard-control logic around it.
package grf_scoreboard_pkg;

  localparam int unsigned GRF_AW    = 5;
  localparam int unsigned GRF_NADDR = 32;
  localparam int unsigned GRF_NREG  = 32;
  localparam int unsigned GRF_TW    = 2;
  localparam int unsigned GRF_CW    = 2;

  localparam logic [GRF_AW-1:0] GRF_REG_ZERO = '0;

  function automatic logic is_zero_reg(input logic [GRF_AW-1:0] addr);
    return addr == GRF_REG_ZERO;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One tracked register: Tnew countdown timer plus a saturating in-flight writer count.
module sb_entry
  import grf_scoreboard_pkg::*;
#(
  parameter int unsigned TW = GRF_TW,
  parameter int unsigned CW = GRF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          issue,
  input  logic          retire,
  input  logic [TW-1:0] tnew,
  output logic [TW-1:0] timer,
  output logic [CW-1:0] inflight,
  output logic          busy
);

  localparam logic [CW-1:0] INFL_MAX = '1;

  logic [TW-1:0] timer_next;
  logic [CW-1:0] inflight_next;

  // A matching issue and retire cancel out; saturate both ends of the count.
  always_comb begin
    timer_next    = (timer != '0) ? timer - TW'(1) : timer;
    inflight_next = inflight;
    if (issue) begin
      timer_next = tnew;
    end
    if (issue && !retire) begin
      if (inflight != INFL_MAX) begin
        inflight_next = inflight + CW'(1);
      end
    end else if (retire && !issue) begin
      if (inflight != '0) begin
        inflight_next = inflight - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      timer    <= '0;
      inflight <= '0;
      busy     <= 1'b0;
    end else begin
      timer    <= timer_next;
      inflight <= inflight_next;
      busy     <= (inflight_next != '0);
    end
  end

endmodule

// File: rtl/grf_scoreboard.sv
// GRF write scoreboard: tracks pending writers per register and raises a
// combinational D-stage stall when a source is not yet forwardable.
module grf_scoreboard
  import grf_scoreboard_pkg::*;
#(
  parameter int unsigned NREG = GRF_NREG,
  parameter int unsigned TW   = GRF_TW,
  parameter int unsigned CW   = GRF_CW
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              issue_valid,
  input  logic [GRF_AW-1:0] issue_dst,
  input  logic [TW-1:0]     issue_tnew,
  input  logic              wb_valid,
  input  logic [GRF_AW-1:0] wb_dst,
  input  logic [GRF_AW-1:0] A1,
  input  logic [GRF_AW-1:0] A2,
  input  logic [TW-1:0]     tuse1,
  input  logic [TW-1:0]     tuse2,
  input  logic              clr,
  output logic              stall,
  output logic [NREG-1:0]   busy
);

  // Entry arrays span the full 5-bit address space; slots 0 and >= NREG read as idle.
  logic [TW-1:0]        timer    [GRF_NADDR];
  logic [CW-1:0]        inflight [GRF_NADDR];
  logic [GRF_NADDR-1:0] pend;
  logic                 accept;
  logic                 hz1;
  logic                 hz2;

  assign accept = issue_valid && !stall && !is_zero_reg(issue_dst);

  for (genvar r = 0; r < GRF_NADDR; r++) begin : g_reg
    if (r != 0 && r < NREG) begin : g_ent
      sb_entry #(
        .TW (TW),
        .CW (CW)
      ) u_entry (
        .clk      (clk),
        .reset    (RESET),
        .clr      (clr),
        .issue    (accept && (issue_dst == GRF_AW'(r))),
        .retire   (wb_valid && (wb_dst == GRF_AW'(r))),
        .tnew     (issue_tnew),
        .timer    (timer[r]),
        .inflight (inflight[r]),
        .busy     (pend[r])
      );
    end else begin : g_none
      assign timer[r]    = '0;
      assign inflight[r] = '0;
      assign pend[r]     = 1'b0;
    end
  end

  // A retire of the last writer this cycle is covered by the GRF's internal bypass.
  always_comb begin
    hz1 = !is_zero_reg(A1) && pend[A1] && (timer[A1] > tuse1)
          && !(wb_valid && (wb_dst == A1) && (inflight[A1] == CW'(1)));
    hz2 = !is_zero_reg(A2) && pend[A2] && (timer[A2] > tuse2)
          && !(wb_valid && (wb_dst == A2) && (inflight[A2] == CW'(1)));
  end

  assign stall = hz1 | hz2;
  assign busy  = pend[NREG-1:0];

endmodule

// File: tb/tb_grf_scoreboard.sv
// Bench for grf_scoreboard: directed scenarios plus randomized traffic against
// a per-register count/timer model.
module tb_grf_scoreboard;

  localparam int NREG = 32;
  localparam int INFL_MAX = 3;

  logic            clk = 1'b0;
  logic            RESET;
  logic            issue_valid;
  logic [4:0]      issue_dst;
  logic [1:0]      issue_tnew;
  logic            wb_valid;
  logic [4:0]      wb_dst;
  logic [4:0]      A1;
  logic [4:0]      A2;
  logic [1:0]      tuse1;
  logic [1:0]      tuse2;
  logic            clr;
  logic            stall;
  logic [NREG-1:0] busy;

  int total = 0;
  int bad   = 0;
  bit model_ok = 1'b0;
  int m_timer [NREG];
  int m_infl  [NREG];

  grf_scoreboard dut (
    .clk         (clk),
    .RESET       (RESET),
    .issue_valid (issue_valid),
    .issue_dst   (issue_dst),
    .issue_tnew  (issue_tnew),
    .wb_valid    (wb_valid),
    .wb_dst      (wb_dst),
    .A1          (A1),
    .A2          (A2),
    .tuse1       (tuse1),
    .tuse2       (tuse2),
    .clr         (clr),
    .stall       (stall),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A source must wait while a writer is pending whose result arrives after it is needed.
  function automatic bit m_hz(input logic [4:0] a, input logic [1:0] tu);
    if (a == 0 || int'(a) >= NREG) return 1'b0;
    if (m_infl[a] == 0) return 1'b0;
    if (m_timer[a] <= int'(tu)) return 1'b0;
    if (wb_valid && wb_dst == a && m_infl[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    return m_hz(A1, tuse1) || m_hz(A2, tuse2);
  endfunction

  function automatic logic [NREG-1:0] m_busy();
    logic [NREG-1:0] v = '0;
    for (int r = 1; r < NREG; r++) v[r] = (m_infl[r] != 0);
    return v;
  endfunction

  task automatic compare_model();
    if (model_ok) begin
      check("stall_vs_model", 32'(stall), 32'(m_stall()));
      check("busy_vs_model", 32'(busy), 32'(m_busy()));
    end
  endtask

  // Called just after posedge: inputs are still those the DUT sampled.
  task automatic model_update();
    bit acc;
    int iss_r;
    int ret_r;
    acc   = issue_valid && !m_stall() && issue_dst != 0;
    iss_r = acc ? int'(issue_dst) : -1;
    ret_r = (wb_valid && wb_dst != 0) ? int'(wb_dst) : -1;
    if (RESET || clr) begin
      for (int r = 0; r < NREG; r++) begin
        m_timer[r] = 0;
        m_infl[r]  = 0;
      end
      if (RESET) model_ok = 1'b1;
    end else begin
      for (int r = 1; r < NREG; r++) if (m_timer[r] > 0) m_timer[r]--;
      if (iss_r > 0) m_timer[iss_r] = int'(issue_tnew);
      if (!(iss_r > 0 && iss_r == ret_r)) begin
        if (iss_r > 0 && m_infl[iss_r] < INFL_MAX) m_infl[iss_r]++;
        if (ret_r > 0 && m_infl[ret_r] > 0) m_infl[ret_r]--;
      end
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] idst, input logic [1:0] itn,
                       input logic wv, input logic [4:0] wdst,
                       input logic [4:0] a1, input logic [1:0] t1,
                       input logic [4:0] a2, input logic [1:0] t2,
                       input logic c, input logic rst);
    issue_valid = iv;  issue_dst = idst; issue_tnew = itn;
    wb_valid    = wv;  wb_dst    = wdst;
    A1 = a1; tuse1 = t1; A2 = a2; tuse2 = t2;
    clr = c; RESET = rst;
    #1;
    compare_model();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); adv();
    for (int i = 0; i < 3; i++) begin
      idle();
      check("reset_idle_busy", 32'(busy), 32'h0);
      check("reset_idle_stall", 32'(stall), 32'h0);
      adv();
    end

    // issue r5 tnew=2, then consumer with tuse=0 waits two cycles
    drive(1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    check("r5_issue_stall", 32'(stall), 32'h0); adv();
    drive(0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    check("r5_stall_t2", 32'(stall), 32'h1); adv();
    drive(0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    check("r5_stall_t1", 32'(stall), 32'h1); adv();
    drive(0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    check("r5_stall_t0", 32'(stall), 32'h0);
    check("r5_busy", 32'(busy[5]), 32'h1); adv();
    drive(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0); adv();
    idle();
    check("r5_busy_retired", 32'(busy[5]), 32'h0); adv();

    // issue r8 tnew=1, consumer with tuse=1 never stalls
    drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0);
    check("r8_no_stall", 32'(stall), 32'h0);
    check("r8_busy", 32'(busy[8]), 32'h1); adv();
    drive(0, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0);
    check("r8_busy_at_wb", 32'(busy[8]), 32'h1); adv();
    idle();
    check("r8_busy_cleared", 32'(busy[8]), 32'h0); adv();

    // two writers to r3 need two retires
    drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0); adv();
    drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0); adv();
    idle();
    check("r3_busy_one_left", 32'(busy[3]), 32'h1); adv();
    drive(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0); adv();
    idle();
    check("r3_busy_done", 32'(busy[3]), 32'h0); adv();
    drive(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0); adv();
    drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0); adv();
    idle();
    check("r3_no_underflow", 32'(busy[3]), 32'h0); adv();

    // register 0 is never tracked
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    check("r0_stall", 32'(stall), 32'h0); adv();
    idle();
    check("r0_busy", 32'(busy), 32'h0); adv();

    // clr, then RESET, each while a new issue to r4 is offered
    for (int k = 0; k < 2; k++) begin
      drive(1, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0); adv();
      drive(1, 4, 3, 0, 0, 0, 0, 0, 0, (k == 0), (k == 1));
      check("r4_busy_before_flush", 32'(busy[4]), 32'h1); adv();
      drive(0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0);
      check("r4_stall_after_flush", 32'(stall), 32'h0);
      check("r4_busy_after_flush", 32'(busy), 32'h0); adv();
    end

    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 1) == 1), pick_reg(), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) < 4), pick_reg(),
            pick_reg(), 2'($urandom_range(0, 3)),
            pick_reg(), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 63) == 0), ($urandom_range(0, 127) == 0));
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
